// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed 8-digit hex display driver with frame-aligned updates.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic        frame_done
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [31:0]   shadow, disp;
    logic          pending, wrap;
    logic          tick, bnd, blank;
    logic [3:0]    nib;
    logic [6:0]    hex;
    assign tick  = div_cnt == DW'(SCAN_DIV - 1);
    assign bnd   = tick && idx == 3'd7;
    assign nib   = disp[{idx, 2'b00} +: 4];
    // A digit is leading-zero when it and everything above it is zero; digit 0 always shows.
    assign blank = blank_lz && idx != 3'd0 && (disp >> {idx, 2'b00}) == 32'd0;
    always_comb begin
        hex = 7'h7F;
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt    <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            wrap       <= 1'b0;
            o_seg      <= 8'hFF;
            o_sel      <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) idx <= idx + 1'b1;
            if (load) shadow <= data_in;
            // A load landing on the boundary bypasses the shadow so it shows one cycle later.
            if (bnd) disp <= load ? data_in : (pending ? shadow : disp);
            pending    <= bnd ? 1'b0 : (pending | load);
            wrap       <= bnd;
            frame_done <= wrap;
            o_seg      <= blank ? 8'hFF : {~dp_mask[idx], hex};
            o_sel      <= ~(8'h01 << idx);
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: vector table, corner sequences and a random run against a frame-level model.
module tb_seg7_scan_driver;
    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, blank_lz = 1'b0;
    logic [31:0] data_in = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  o_seg, o_sel;
    logic        frame_done;

    seg7_scan_driver #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_mask(dp_mask),
        .blank_lz(blank_lz), .o_seg(o_seg), .o_sel(o_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic [31:0] value;
        logic        blz;
        logic [7:0]  dpm;
        logic [63:0] segs;
    } vec_t;

    int          tests = 0, fails = 0;
    int          m_cnt;
    logic [31:0] m_disp, m_shadow;
    logic        m_pend;
    logic [7:0]  e_seg, e_sel;
    logic        e_fd;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] ref_seg(input logic [31:0] v, input int k, input logic blz,
                                           input logic [7:0] dpm);
        int hi = 0;
        for (int j = 0; j < 8; j++) if (v[4*j +: 4] != 4'h0) hi = j;
        if (blz && k > hi) return 8'hFF;
        return {~dpm[k], HEX[v[4*k +: 4]][6:0]};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    endtask

    task automatic model_edge();
        int k = (m_cnt / 4) % 8;
        e_sel = ~(8'h01 << k);
        e_seg = ref_seg(m_disp, k, blank_lz, dp_mask);
        e_fd  = m_cnt > 0 && m_cnt % 32 == 0;
        if (m_cnt % 32 == 31) begin
            if (load) begin
                m_disp = data_in; m_shadow = data_in; m_pend = 1'b0;
            end else if (m_pend) begin
                m_disp = m_shadow; m_pend = 1'b0;
            end
        end else if (load) begin
            m_shadow = data_in; m_pend = 1'b1;
        end
        m_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", {47'b0, o_seg, o_sel, frame_done}, {47'b0, e_seg, e_sel, e_fd});
    endtask

    task automatic to_boundary();
        while (m_cnt % 32 != 31) step();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1 chk("rst_async", {47'b0, o_seg, o_sel, frame_done}, {47'b0, 8'hFF, 8'hFF, 1'b0});
        @(posedge clk);
        #1 chk("rst_hold", {47'b0, o_seg, o_sel, frame_done}, {47'b0, 8'hFF, 8'hFF, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        model_reset();
    endtask

    task automatic load_pulse(input logic [31:0] v);
        data_in = v; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        int seen2;
        vecs[0] = '{32'h89ABCDEF, 1'b0, 8'h00, 64'h80908883C6A1868E};
        vecs[1] = '{32'h00000A05, 1'b1, 8'h00, 64'hFFFFFFFFFF88C092};
        vecs[2] = '{32'h00000000, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFC0};
        vecs[3] = '{32'h00000005, 1'b0, 8'h01, 64'hC0C0C0C0C0C0C012};
        vecs[4] = '{32'h00000A05, 1'b1, 8'h04, 64'hFFFFFFFFFF08C092};
        vecs[5] = '{32'h12345678, 1'b1, 8'h80, 64'h79A4B0999282F880};
        vecs[6] = '{32'h00000001, 1'b1, 8'hFF, 64'hFFFFFFFFFFFFFF79};

        do_reset();
        step();
        chk("rst_release", {48'b0, o_sel, o_seg}, {48'b0, 8'hFE, 8'hC0});

        // Load during digit 3 of a zero frame: the rest of this frame must stay zero.
        while (m_cnt != 13) step();
        load_pulse(32'h11111111);
        while (m_cnt < 32) begin
            step();
            if (m_cnt - 1 >= 16) chk("tear_old", {56'b0, o_seg}, {56'b0, 8'hC0});
        end
        for (int i = 0; i < 32; i++) begin
            step();
            chk("tear_new", {56'b0, o_seg}, {56'b0, 8'hF9});
        end

        // Two loads in one frame: only the last may ever reach the display.
        to_boundary();
        step();
        while (m_cnt % 32 != 5) step();
        load_pulse(32'h22222222);
        while (m_cnt % 32 != 20) step();
        load_pulse(32'h33333333);
        seen2 = 0;
        to_boundary();
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            if (o_seg == 8'hA4) seen2++;
            chk("ovw_new", {56'b0, o_seg}, {56'b0, 8'hB0});
        end
        chk("ovw_never2", 64'(seen2), 64'd0);

        foreach (vecs[v]) begin
            blank_lz = vecs[v].blz;
            dp_mask  = vecs[v].dpm;
            to_boundary();
            load_pulse(vecs[v].value);
            for (int i = 0; i < 32; i++) begin
                step();
                if (i == 0) begin
                    chk("bnd_latency", {56'b0, o_seg}, {56'b0, vecs[v].segs[7:0]});
                    chk("vec_fd", {63'b0, frame_done}, 64'd1);
                end
                chk("vec_sel", {56'b0, o_sel}, {56'b0, ~(8'h01 << (i / 4))});
                chk("vec_seg", {56'b0, o_seg}, {56'b0, vecs[v].segs[8*(i/4) +: 8]});
            end
        end

        // Mid-scan reset drops a pending value.
        blank_lz = 1'b0;
        dp_mask  = 8'h00;
        while (m_cnt % 32 != 10) step();
        load_pulse(32'h77777777);
        for (int i = 0; i < 3; i++) step();
        do_reset();
        for (int i = 0; i < 48; i++) begin
            step();
            chk("rst_lost", {56'b0, o_seg}, {56'b0, 8'hC0});
        end

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) blank_lz = 1'($urandom);
            if ($urandom_range(0, 39) == 0) dp_mask = 8'($urandom);
            data_in = $urandom >> (4 * $urandom_range(0, 8));
            load = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
